// File: rtl/paddle_if.sv
// Paddle controller bus: frame/button controls in, bounding box and motion status out.
// A frame advances only when i_ani_stb and i_animate are both high on a clock edge; i_endgame overrides it.
interface paddle_if;
   logic        i_endgame;
   logic        i_ani_stb;
   logic        i_animate;
   logic [1:0]  i_btn;
   logic [11:0] o_x1;
   logic [11:0] o_x2;
   logic [11:0] o_y1;
   logic [11:0] o_y2;
   logic        o_active;
   logic [1:0]  o_dir;
   logic [3:0]  o_vel;
   logic        o_at_min;
   logic        o_at_max;

   modport master (
      output i_endgame, i_ani_stb, i_animate, i_btn,
      input  o_x1, o_x2, o_y1, o_y2, o_active, o_dir, o_vel, o_at_min, o_at_max
   );

   modport slave (
      input  i_endgame, i_ani_stb, i_animate, i_btn,
      output o_x1, o_x2, o_y1, o_y2, o_active, o_dir, o_vel, o_at_min, o_at_max
   );
endinterface

// File: rtl/paddle_ctrl.sv
// Single-axis paddle: button-driven motion on animation ticks with speed ramp and edge clamping.
// o_dir is the FSM state register itself, so the motion state is always observable.
module paddle_ctrl #(
   parameter int HALF_LEN     = 30,
   parameter int HALF_THICK   = 5,
   parameter int ORIENT       = 0,
   parameter int IPOS         = 320,
   parameter int IFIX         = 460,
   parameter int D_WIDTH      = 640,
   parameter int D_HEIGHT     = 480,
   parameter int V_MIN        = 2,
   parameter int V_MAX        = 10,
   parameter int ACCEL_FRAMES = 4
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   paddle_if.slave  pif
);
   localparam int LIM = (ORIENT != 0) ? D_HEIGHT : D_WIDTH;
   localparam int CW  = $clog2(ACCEL_FRAMES + 1);

   localparam logic signed [12:0] PMIN_S  = 13'(HALF_LEN);
   localparam logic signed [12:0] PMAX_S  = 13'(LIM - HALF_LEN);
   localparam logic [11:0]        IPOS_V  = 12'(IPOS);
   localparam logic [11:0]        HLEN_V  = 12'(HALF_LEN);
   localparam logic [3:0]         VMIN_V  = 4'(V_MIN);
   localparam logic [4:0]         VMAX_V  = 5'(V_MAX);
   localparam logic [CW-1:0]      AF_V    = CW'(ACCEL_FRAMES);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      MOVE_POS = 2'b01,
      MOVE_NEG = 2'b10
   } state_t;

   state_t        state, state_nxt, req;
   logic [11:0]   pos, pos_nxt;
   logic [3:0]    vel, vel_nxt, ev;
   logic [CW-1:0] cnt, cnt_nxt, c1;
   logic signed [12:0] target;
   logic [4:0]    vel_up;
   logic          tick;

   assign tick = pif.i_ani_stb & pif.i_animate;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         pos   <= IPOS_V;
         vel   <= VMIN_V;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
         vel   <= vel_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      vel_nxt   = vel;
      cnt_nxt   = cnt;
      ev        = vel;
      c1        = cnt + CW'(1);
      target    = signed'({1'b0, pos});
      vel_up    = 5'd0;

      unique case (pif.i_btn)
         2'b01:   req = MOVE_POS;
         2'b10:   req = MOVE_NEG;
         default: req = IDLE;
      endcase

      if (pif.i_endgame) begin
         state_nxt = IDLE;
         pos_nxt   = IPOS_V;
         vel_nxt   = VMIN_V;
         cnt_nxt   = '0;
      end else if (tick) begin
         state_nxt = req;
         if (req == IDLE) begin
            vel_nxt = VMIN_V;
            cnt_nxt = '0;
         end else begin
            // A fresh direction (including instant reversal) restarts the ramp.
            if (req != state) begin
               ev = VMIN_V;
               c1 = CW'(1);
            end
            vel_up = {1'b0, ev} + 5'd1;
            if (req == MOVE_POS)
               target = signed'({1'b0, pos}) + signed'({9'd0, ev});
            else
               target = signed'({1'b0, pos}) - signed'({9'd0, ev});

            if (target >= PMAX_S) begin
               pos_nxt = PMAX_S[11:0];
               vel_nxt = VMIN_V;
               cnt_nxt = '0;
            end else if (target <= PMIN_S) begin
               pos_nxt = PMIN_S[11:0];
               vel_nxt = VMIN_V;
               cnt_nxt = '0;
            end else begin
               pos_nxt = target[11:0];
               if (c1 == AF_V) begin
                  cnt_nxt = '0;
                  vel_nxt = (vel_up > VMAX_V) ? VMAX_V[3:0] : vel_up[3:0];
               end else begin
                  cnt_nxt = c1;
                  vel_nxt = ev;
               end
            end
         end
      end
   end

   logic [11:0] along_lo, along_hi, cross_lo, cross_hi;
   assign along_lo = pos - HLEN_V;
   assign along_hi = pos + HLEN_V;
   assign cross_lo = 12'(IFIX - HALF_THICK);
   assign cross_hi = 12'(IFIX + HALF_THICK);

   assign pif.o_x1     = (ORIENT != 0) ? cross_lo : along_lo;
   assign pif.o_x2     = (ORIENT != 0) ? cross_hi : along_hi;
   assign pif.o_y1     = (ORIENT != 0) ? along_lo : cross_lo;
   assign pif.o_y2     = (ORIENT != 0) ? along_hi : cross_hi;
   assign pif.o_active = |pif.i_btn;
   assign pif.o_dir    = state;
   assign pif.o_vel    = vel;
   assign pif.o_at_min = (pos == PMIN_S[11:0]);
   assign pif.o_at_max = (pos == PMAX_S[11:0]);
endmodule
